keypad_scan_ctrl: RTL

- Scan controller for the vending machine's 4x4 matrix keypad.
- Drives the active-low column strobe shift_col, samples the active-low row lines and debounces press and release.
- Emits one 4-bit key code with a single-cycle valid strobe per physical keypress.
- Sits between the keypad pins and the vending_machine FSM; replaces direct row/column decoding inside the FSM.

---
 rtl/vm_keypad_pkg.sv | 36 +++
 rtl/keypad_row_sync.sv | 32 +++
 rtl/keypad_scan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vm_keypad_pkg.sv
// Shared definitions for the vending machine keypad scanner.
// Holds the scan FSM state type, the idle/initial line patterns, the key
// codes the vending_machine FSM cares about, and a helper that picks the
// winning row when several rows of one column are low together.
package vm_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Column 0 driven low; all rows released (lines are active-low).
  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Key codes are {col_idx, row_idx}.
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_8 = 4'h8;  // $1 coin
  localparam logic [3:0] KEY_9 = 4'h9;  // $5 note
  localparam logic [3:0] KEY_C = 4'hC;  // count+
  localparam logic [3:0] KEY_F = 4'hF;  // OK

  // Index of the lowest low bit; scanning downward lets the lowest index
  // overwrite any higher one.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines.
// Both stages reset to all-ones so a reset never looks like a keypress.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   d     - asynchronous input lines
//   q     - synchronised copy of d, two clk cycles later
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller for the vending machine.
// Walks an active-low column strobe, samples the synchronised active-low
// rows, debounces press and release, and reports each physical keypress
// once as a key code with a single-cycle valid strobe.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   row       - keypad row lines, active-low, asynchronous to clk
//   shift_col - column drive, exactly one bit low
//   key_code  - {col_idx, row_idx} of the last accepted key
//   key_valid - one-cycle pulse when key_code updates
//   key_held  - high from the key_valid cycle until release is debounced
module keypad_scan_ctrl
  import vm_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int COL_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       row_s;
  scan_state_t      state_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [1:0]       col_ptr_reg;
  logic [3:0]       shift_col_reg;
  logic [1:0]       key_col_reg;
  logic [1:0]       key_row_reg;
  logic [3:0]       pat_reg;
  logic [3:0]       key_code_reg;
  logic             key_valid_reg;
  logic             key_held_reg;

  keypad_row_sync #(
    .WIDTH(4)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d    (row),
    .q    (row_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      col_cnt_reg   <= '0;
      deb_cnt_reg   <= '0;
      col_ptr_reg   <= 2'd0;
      shift_col_reg <= COL_INIT;
      key_col_reg   <= 2'd0;
      key_row_reg   <= 2'd0;
      pat_reg       <= ROW_IDLE;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (col_cnt_reg == COL_LAST) begin
            if (row_s == ROW_IDLE) begin
              shift_col_reg <= {shift_col_reg[2:0], shift_col_reg[3]};
              col_ptr_reg   <= col_ptr_reg + 2'd1;
              col_cnt_reg   <= '0;
            end else begin
              // Column stays frozen: shift_col/col_ptr are not advanced.
              key_col_reg <= col_ptr_reg;
              key_row_reg <= lowest_low_row(row_s);
              pat_reg     <= row_s;
              deb_cnt_reg <= '0;
              state_reg   <= DEBOUNCE;
            end
          end else begin
            col_cnt_reg <= col_cnt_reg + COL_W'(1);
          end
        end

        DEBOUNCE: begin
          if (row_s != pat_reg) begin
            // Bounce or glitch: abandon quietly and move on.
            state_reg     <= SCAN;
            shift_col_reg <= {shift_col_reg[2:0], shift_col_reg[3]};
            col_ptr_reg   <= col_ptr_reg + 2'd1;
            col_cnt_reg   <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= HOLD;
            key_code_reg  <= {key_col_reg, key_row_reg};
            key_valid_reg <= 1'b1;
            key_held_reg  <= 1'b1;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
          end
        end

        HOLD: begin
          if (row_s == ROW_IDLE) begin
            state_reg   <= RELEASE;
            deb_cnt_reg <= '0;
          end
        end

        RELEASE: begin
          if (row_s != ROW_IDLE) begin
            // Release bounce: the key is still considered held.
            state_reg <= HOLD;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= SCAN;
            key_held_reg  <= 1'b0;
            shift_col_reg <= {shift_col_reg[2:0], shift_col_reg[3]};
            col_ptr_reg   <= col_ptr_reg + 2'd1;
            col_cnt_reg   <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
          end
        end

        default: state_reg <= SCAN;
      endcase
    end
  end

  assign shift_col = shift_col_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule
